// File: rtl/frac_baud_generator.sv
// Fractional-N baud tick generator: a phase accumulator carry gives the oversample
// tick, and a small prescaler on that tick gives the bit-boundary and mid-bit ticks.
module frac_baud_generator #(
  parameter int CLOCK_HZ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 24,
  parameter logic [ACC_W-1:0] INC_DEFAULT =
    ACC_W'(((64'(BAUD) * 64'(OVERSAMPLE) << ACC_W) + 64'(CLOCK_HZ / 2)) / 64'(CLOCK_HZ)),
  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             restart,
  input  logic             cfg_load,
  input  logic [ACC_W-1:0] cfg_inc,
  output logic             os_tick,
  output logic             bit_tick,
  output logic             mid_tick,
  output logic [CNT_W-1:0] os_cnt,
  output logic [ACC_W-1:0] inc
);

  // With a single oversample per bit the mid-bit point collapses onto index 0,
  // so every tick is simultaneously an os, bit and mid tick.
  localparam int MID_IDX  = (OVERSAMPLE > 1) ? (OVERSAMPLE / 2 - 1) : 0;
  localparam int LAST_IDX = OVERSAMPLE - 1;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
  logic             os_tick_q, os_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             mid_tick_q, mid_tick_d;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic             at_last;
  logic             at_mid;

  assign sum     = {1'b0, acc_q} + {1'b0, inc_q};
  assign carry   = sum[ACC_W];
  assign at_last = (os_cnt_q == CNT_W'(LAST_IDX));
  assign at_mid  = (os_cnt_q == CNT_W'(MID_IDX));

  always_comb begin
    acc_d      = acc_q;
    os_cnt_d   = os_cnt_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;
    // The increment register is independent of the phase path; the add this
    // cycle always sees the old value.
    inc_d      = cfg_load ? cfg_inc : inc_q;

    if (restart) begin
      acc_d    = '0;
      os_cnt_d = '0;
    end else if (run) begin
      acc_d     = sum[ACC_W-1:0];
      os_tick_d = carry;
      if (carry) begin
        os_cnt_d   = at_last ? '0 : os_cnt_q + CNT_W'(1);
        bit_tick_d = at_last;
        mid_tick_d = at_mid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      inc_q      <= INC_DEFAULT;
      os_cnt_q   <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      inc_q      <= inc_d;
      os_cnt_q   <= os_cnt_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
    end
  end

  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;
  assign mid_tick = mid_tick_q;
  assign os_cnt   = os_cnt_q;
  assign inc      = inc_q;

endmodule

// File: tb/tb_frac_baud_generator.sv
// Bench for frac_baud_generator (ACC_W=24, OVERSAMPLE=4): directed steps plus
// randomized traffic checked against an unbounded-phase reference model.
module tb_frac_baud_generator;

  localparam int ACC_W = 24;
  localparam int OS    = 4;
  localparam logic [ACC_W-1:0] INC_DEF = 24'd77309; // round(115200*4*2^24/1e8)

  logic             clk;
  logic             rst;
  logic             run;
  logic             restart;
  logic             cfg_load;
  logic [ACC_W-1:0] cfg_inc;
  logic             os_tick;
  logic             bit_tick;
  logic             mid_tick;
  logic [1:0]       os_cnt;
  logic [ACC_W-1:0] inc;

  int checks   = 0;
  int failures = 0;

  // Reference model: total phase never wraps; ticks are integer crossings.
  longint unsigned  m_phase;
  int               m_nticks;
  logic [ACC_W-1:0] m_inc;
  logic             e_os, e_bit, e_mid;

  int n_os, n_bit, first_at, edge_idx;

  frac_baud_generator #(
    .CLOCK_HZ(100_000_000), .BAUD(115_200), .OVERSAMPLE(OS), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .restart(restart),
    .cfg_load(cfg_load), .cfg_inc(cfg_inc),
    .os_tick(os_tick), .bit_tick(bit_tick), .mid_tick(mid_tick),
    .os_cnt(os_cnt), .inc(inc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_nticks = 0;
    m_inc    = INC_DEF;
    e_os = 1'b0; e_bit = 1'b0; e_mid = 1'b0;
  endtask

  task automatic model_step(input logic rs, input logic rn, input logic ld,
                            input logic [ACC_W-1:0] ci);
    longint unsigned np;
    e_os = 1'b0; e_bit = 1'b0; e_mid = 1'b0;
    if (rs) begin
      m_phase  = 0;
      m_nticks = 0;
    end else if (rn) begin
      np = m_phase + longint'(m_inc);
      if ((np >> ACC_W) != (m_phase >> ACC_W)) begin
        m_nticks++;
        e_os  = 1'b1;
        e_bit = (m_nticks % OS) == 0;
        e_mid = (m_nticks % OS) == OS / 2;
      end
      m_phase = np;
    end
    if (ld) m_inc = ci;
  endtask

  // One clock edge: drive, advance model, sample 1 time unit after the edge.
  task automatic step(input logic rs, input logic rn, input logic ld,
                      input logic [ACC_W-1:0] ci);
    restart = rs; run = rn; cfg_load = ld; cfg_inc = ci;
    @(posedge clk);
    model_step(rs, rn, ld, ci);
    #1;
    edge_idx++;
    check("os_tick", 64'(os_tick), 64'(e_os));
    check("bit_tick", 64'(bit_tick), 64'(e_bit));
    check("mid_tick", 64'(mid_tick), 64'(e_mid));
    check("os_cnt", 64'(os_cnt), 64'(m_nticks % OS));
    check("inc", 64'(inc), 64'(m_inc));
    if (os_tick) begin
      n_os++;
      if (first_at < 0) first_at = edge_idx;
    end
    if (bit_tick) n_bit++;
  endtask

  task automatic clear_counts();
    n_os = 0; n_bit = 0; first_at = -1; edge_idx = 0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; restart = 1'b0; cfg_load = 1'b0; cfg_inc = '0;
    model_reset();
    clear_counts();
    #1;
    check("reset_os_tick", 64'(os_tick), 64'd0);
    check("reset_bit_tick", 64'(bit_tick), 64'd0);
    check("reset_mid_tick", 64'(mid_tick), 64'd0);
    check("reset_os_cnt", 64'(os_cnt), 64'd0);
    check("reset_inc", 64'(inc), 64'(INC_DEF));
    @(negedge clk);
    rst = 1'b0;

    // 1: inc = 2^21 -> period 8, bit every 32
    step(1'b0, 1'b0, 1'b1, 24'h20_0000);
    clear_counts();
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("t1_first_tick_edge", 64'(first_at), 64'd8);
    check("t1_os_count", 64'(n_os), 64'd8);
    check("t1_bit_count", 64'(n_bit), 64'd2);

    // 2: restart and load together, inc = 3*2^21 -> 30 ticks in 80 cycles
    step(1'b1, 1'b1, 1'b1, 24'h60_0000);
    clear_counts();
    for (int i = 0; i < 80; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("t2_os_count_80", 64'(n_os), 64'd30);

    // 3: run low for 5 cycles mid-period delays the tick by 5
    step(1'b1, 1'b0, 1'b1, 24'h20_0000);
    clear_counts();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, '0);
    check("t3_no_tick_while_low", 64'(n_os), 64'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("t3_delayed_first_tick", 64'(first_at), 64'd13);

    // 4: restart at os_cnt=2 on the cycle a carry would occur
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 23; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("t4_os_cnt_before", 64'(os_cnt), 64'd2);
    clear_counts();
    step(1'b1, 1'b1, 1'b0, '0);
    check("t4_no_tick_on_restart", 64'(n_os), 64'd0);
    clear_counts();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("t4_next_tick_edge", 64'(first_at), 64'd8);

    // 5: cfg_load of 2^22 mid-period
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);
    clear_counts();
    step(1'b0, 1'b1, 1'b1, 24'h40_0000);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("t5_os_count_after_load", 64'(n_os), 64'd5);

    // Boundary: largest increment ticks nearly every cycle
    step(1'b1, 1'b0, 1'b1, 24'hFF_FFFF);
    clear_counts();
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("max_inc_os_count", 64'(n_os), 64'd39);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [ACC_W-1:0] ci;
      ci = ($urandom_range(0, 19) == 0) ? 24'(0) : 24'($urandom_range(1 << 18, 1 << 23));
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 39) == 0, ci);
    end

    // 6: asynchronous reset between edges while ticking
    step(1'b1, 1'b0, 1'b1, 24'h20_0000);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("t6_tick_before_rst", 64'(os_tick), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_os_tick", 64'(os_tick), 64'd0);
    check("t6_rst_os_cnt", 64'(os_cnt), 64'd0);
    check("t6_rst_inc", 64'(inc), 64'(INC_DEF));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b1, 24'h0);
    clear_counts();
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("t6_inc0_no_ticks", 64'(n_os), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frac_baud_generator.md
Name: frac_baud_generator

Overview:
Fractional-N baud tick generator. Successor to the integer-divider baud generator.
- A phase accumulator produces an oversample tick at any rational rate, with no integer-DIV rounding error.
- A prescaler derives bit-rate and mid-bit ticks from the oversample tick.
- Increment is runtime-reloadable, and phase can be restarted so a UART RX can lock to a start-bit edge.
- Sits between the system clock and the UART TX/RX datapaths.

Parameters:
CLOCK_HZ, 100_000_000, system clock frequency (used only for INC_DEFAULT)
BAUD, 115_200, default baud rate (used only for INC_DEFAULT)
OVERSAMPLE, 16, oversample ticks per bit; integer >= 1
ACC_W, 24, phase accumulator width, 8..32
INC_DEFAULT, round(BAUD*OVERSAMPLE*2^ACC_W/CLOCK_HZ), reset value of increment; overridable
CNT_W, max(1,$clog2(OVERSAMPLE)), width of os_cnt (derived localparam)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
run  input  1  1 = accumulate; 0 = freeze phase and counters
restart  input  1  1-cycle pulse: zero phase and oversample count
cfg_load  input  1  1-cycle pulse: load cfg_inc into the increment register
cfg_inc  input  ACC_W  new increment value
os_tick  output  1  1-cycle pulse per oversample period
bit_tick  output  1  1-cycle pulse per OVERSAMPLE os_ticks (bit boundary)
mid_tick  output  1  1-cycle pulse at mid-bit
os_cnt  output  CNT_W  os_ticks since last bit boundary, 0..OVERSAMPLE-1
inc  output  ACC_W  current increment register (readback)

Behaviour:
- Reset, asynchronous and immediate:
  - acc=0, os_cnt=0, inc=INC_DEFAULT.
  - os_tick=0, bit_tick=0, mid_tick=0.
- All outputs are registered. No combinational input-to-output paths.
- Each edge, priority order:
  - restart=1:
    - acc<=0, os_cnt<=0, all ticks<=0.
    - Any in-flight carry is discarded.
  - else run=1:
    - {carry,acc}<=acc+inc, computed at ACC_W+1 bits; acc wraps mod 2^ACC_W.
    - os_tick<=carry.
    - If carry: os_cnt<=(os_cnt==OVERSAMPLE-1)?0:os_cnt+1.
    - If carry: bit_tick<=(os_cnt==OVERSAMPLE-1).
    - If carry: mid_tick<=(os_cnt==OVERSAMPLE/2-1).
    - If no carry: all ticks<=0, os_cnt holds.
  - else (run=0): acc and os_cnt hold, all ticks<=0.
- OVERSAMPLE==1: bit_tick and mid_tick both equal os_tick; os_cnt is constantly 0.
- Any tick is high for exactly one cycle. bit_tick and mid_tick are only ever high together with os_tick.
- Tick timing:
  - Average os_tick period is 2^ACC_W/inc cycles.
  - Individual periods are floor or ceil of that value, never more than one cycle apart.
- First os_tick after reset or restart, with run=1 continuously: ceil(2^ACC_W/inc) edges later.
- cfg_load:
  - inc<=cfg_inc at the edge where cfg_load=1.
  - The addition in that same cycle uses the old inc.
  - acc and os_cnt are not disturbed.
  - Applies regardless of run. restart and cfg_load in the same cycle are both honoured.
- inc=0: no ticks ever; acc holds its value.
- inc=2^ACC_W-1: os_tick on every cycle except one per 2^ACC_W cycles.
- rst mid-operation: all state returns to reset values immediately, including an inc loaded via cfg_load.

Test Plan:
1. ACC_W=24, OVERSAMPLE=4, inc=2^21 via cfg_load, run=1 -> os_tick every 8 cycles, width 1. bit_tick every 32 cycles with os_cnt 3->0. mid_tick on the os_tick where os_cnt 1->2. First os_tick 8 edges after the run start.
2. inc=3*2^21 -> os_tick period sequence repeats 3,3,2. Over 80 cycles, exactly 30 ticks.
3. run dropped for 5 cycles mid-period -> no ticks while low. The next tick is delayed by exactly 5 cycles. os_cnt is unchanged.
4. restart at os_cnt=2 with a carry pending that cycle -> no tick that cycle. os_cnt=0, and the next os_tick comes 8 edges later.
5. cfg_load of inc=2^22 mid-period -> the old rate applies through the load cycle, then the period becomes 4. The phase is continuous, with no spurious double tick.
6. Assert rst asynchronously between edges while ticks are running -> outputs clear immediately and inc==INC_DEFAULT. inc=0 afterwards -> no ticks in 1000 cycles.
